// File: rtl/region_attr_table.sv
// rtl/region_attr_table.sv - region attribute table with config port and per-port lookup slices
//
// Purpose: holds NR_RULES address regions (base, len, {nonidem, exec, cached}
// attributes, lock bit) and resolves attributes for NR_PORTS independent
// lookup channels. The lowest matching rule index wins. A miss returns
// MISS_ATTR.
//
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   cfg_*              single-cycle register access (registered response)
//   lk_valid_i/ready_o request handshake per port, lk_addr_i address per port
//   lk_valid_o/ready_i result handshake per port, lk_hit_o/lk_attr_o result
module region_attr_table #(
  parameter int unsigned NR_RULES = 4,
  parameter int unsigned PLEN     = 34,
  parameter int unsigned NR_PORTS = 2,
  parameter logic [NR_RULES*PLEN-1:0] RST_BASE = '0,
  parameter logic [NR_RULES*PLEN-1:0] RST_LEN  = '0,
  parameter logic [NR_RULES*3-1:0]    RST_ATTR = '0,
  parameter logic [2:0]               MISS_ATTR = 3'b100,
  localparam int unsigned IW = (NR_RULES > 1) ? $clog2(NR_RULES) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cfg_req_i,
  input  logic                   cfg_we_i,
  input  logic [IW-1:0]          cfg_idx_i,
  input  logic [1:0]             cfg_field_i,
  input  logic [PLEN-1:0]        cfg_wdata_i,
  output logic                   cfg_rvalid_o,
  output logic [PLEN-1:0]        cfg_rdata_o,
  output logic                   cfg_err_o,
  input  logic [NR_PORTS-1:0]    lk_valid_i,
  output logic [NR_PORTS-1:0]    lk_ready_o,
  input  logic [NR_PORTS*PLEN-1:0] lk_addr_i,
  output logic [NR_PORTS-1:0]    lk_valid_o,
  input  logic [NR_PORTS-1:0]    lk_ready_i,
  output logic [NR_PORTS-1:0]    lk_hit_o,
  output logic [NR_PORTS*3-1:0]  lk_attr_o
);

  logic [PLEN-1:0] r_base [NR_RULES];
  logic [PLEN-1:0] r_len  [NR_RULES];
  logic [2:0]      r_attr [NR_RULES];
  logic [NR_RULES-1:0] r_lock;

  logic            r_cfg_rvalid;
  logic [PLEN-1:0] r_cfg_rdata;
  logic            r_cfg_err;

  logic            w_idx_ok;
  logic            w_sel_lock;

  assign w_idx_ok   = ({1'b0, cfg_idx_i} < (IW+1)'(NR_RULES));
  assign w_sel_lock = w_idx_ok ? r_lock[cfg_idx_i] : 1'b1;

  // End of region is computed one bit wider so a region ending exactly at
  // the top of the address space does not wrap around to zero.
  function automatic logic f_match(input logic [PLEN-1:0] addr,
                                   input logic [PLEN-1:0] base,
                                   input logic [PLEN-1:0] len);
    logic [PLEN:0] lim;
    lim = {1'b0, base} + {1'b0, len};
    return (len != '0) && (addr >= base) && ({1'b0, addr} < lim);
  endfunction

  // Table and config response
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int r = 0; r < NR_RULES; r++) begin
        r_base[r] <= RST_BASE[r*PLEN +: PLEN];
        r_len[r]  <= RST_LEN[r*PLEN +: PLEN];
        r_attr[r] <= RST_ATTR[r*3 +: 3];
      end
      r_lock       <= '0;
      r_cfg_rvalid <= 1'b0;
      r_cfg_rdata  <= '0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_cfg_rvalid <= cfg_req_i;
      if (cfg_req_i) begin
        r_cfg_rdata <= '0;
        r_cfg_err   <= 1'b0;
        if (cfg_we_i) begin
          if (w_sel_lock || (cfg_field_i == 2'd3)) begin
            r_cfg_err <= 1'b1;
          end else begin
            case (cfg_field_i)
              2'd0: r_base[cfg_idx_i] <= cfg_wdata_i;
              2'd1: r_len[cfg_idx_i]  <= cfg_wdata_i;
              default: begin
                // Attribute and lock land together, so locking can also
                // fix the final attribute value in one access.
                r_attr[cfg_idx_i] <= cfg_wdata_i[2:0];
                r_lock[cfg_idx_i] <= cfg_wdata_i[3];
              end
            endcase
          end
        end else begin
          if (!w_idx_ok || (cfg_field_i == 2'd3)) begin
            r_cfg_err <= 1'b1;
          end else begin
            case (cfg_field_i)
              2'd0:    r_cfg_rdata <= r_base[cfg_idx_i];
              2'd1:    r_cfg_rdata <= r_len[cfg_idx_i];
              default: r_cfg_rdata <= PLEN'({r_lock[cfg_idx_i], r_attr[cfg_idx_i]});
            endcase
          end
        end
      end
    end
  end

  assign cfg_rvalid_o = r_cfg_rvalid;
  assign cfg_rdata_o  = r_cfg_rdata;
  assign cfg_err_o    = r_cfg_err;

  // Lookup channels: each is a one-entry slice evaluated against the table
  // as it stands in the acceptance cycle.
  for (genvar p = 0; p < NR_PORTS; p++) begin : g_port
    logic [PLEN-1:0] w_addr;
    logic            w_hit;
    logic [2:0]      w_attr;
    logic            w_rdy;
    logic            r_vld;
    logic            r_hit;
    logic [2:0]      r_res;

    assign w_addr = lk_addr_i[p*PLEN +: PLEN];

    // Scan from the highest index down so the lowest matching rule wins.
    always_comb begin
      w_hit  = 1'b0;
      w_attr = MISS_ATTR;
      for (int r = NR_RULES - 1; r >= 0; r--) begin
        if (f_match(w_addr, r_base[r], r_len[r])) begin
          w_hit  = 1'b1;
          w_attr = r_attr[r];
        end
      end
    end

    assign w_rdy = !r_vld || lk_ready_i[p];

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        r_vld <= 1'b0;
        r_hit <= 1'b0;
        r_res <= 3'b000;
      end else if (w_rdy && lk_valid_i[p]) begin
        r_vld <= 1'b1;
        r_hit <= w_hit;
        r_res <= w_attr;
      end else if (lk_ready_i[p]) begin
        r_vld <= 1'b0;
      end
    end

    assign lk_ready_o[p]      = !rst_ni || w_rdy;
    assign lk_valid_o[p]      = r_vld;
    assign lk_hit_o[p]        = r_hit;
    assign lk_attr_o[p*3 +: 3] = r_res;
  end

endmodule

// File: tb/tb_region_attr_table.sv
// tb/tb_region_attr_table.sv - directed self-checking bench for region_attr_table
module tb_region_attr_table;

  localparam int NR = 4;
  localparam int PL = 34;
  localparam int NP = 2;
  localparam logic [NR*PL-1:0] RB = {34'h0, 34'h0, 34'h0, 34'h0_8000_0000};
  localparam logic [NR*PL-1:0] RL = {34'h0, 34'h0, 34'h0, 34'h0_4000_0000};
  localparam logic [NR*3-1:0]  RA = 12'b000_000_000_011;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic            cfg_req_i;
  logic            cfg_we_i;
  logic [1:0]      cfg_idx_i;
  logic [1:0]      cfg_field_i;
  logic [PL-1:0]   cfg_wdata_i;
  logic            cfg_rvalid_o;
  logic [PL-1:0]   cfg_rdata_o;
  logic            cfg_err_o;
  logic [NP-1:0]   lk_valid_i;
  logic [NP-1:0]   lk_ready_o;
  logic [NP*PL-1:0] lk_addr_i;
  logic [NP-1:0]   lk_valid_o;
  logic [NP-1:0]   lk_ready_i;
  logic [NP-1:0]   lk_hit_o;
  logic [NP*3-1:0] lk_attr_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  region_attr_table #(
    .NR_RULES(NR), .PLEN(PL), .NR_PORTS(NP),
    .RST_BASE(RB), .RST_LEN(RL), .RST_ATTR(RA), .MISS_ATTR(3'b100)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i),
    .cfg_field_i(cfg_field_i), .cfg_wdata_i(cfg_wdata_i),
    .cfg_rvalid_o(cfg_rvalid_o), .cfg_rdata_o(cfg_rdata_o), .cfg_err_o(cfg_err_o),
    .lk_valid_i(lk_valid_i), .lk_ready_o(lk_ready_o), .lk_addr_i(lk_addr_i),
    .lk_valid_o(lk_valid_o), .lk_ready_i(lk_ready_i),
    .lk_hit_o(lk_hit_o), .lk_attr_o(lk_attr_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [1:0] fld,
                           input logic [PL-1:0] data, input logic exp_err, input string tag);
    cfg_req_i = 1'b1; cfg_we_i = 1'b1; cfg_idx_i = idx; cfg_field_i = fld; cfg_wdata_i = data;
    tick;
    cfg_req_i = 1'b0;
    chk({tag, ".rvalid"}, cfg_rvalid_o, 1'b1);
    chk({tag, ".err"}, cfg_err_o, exp_err);
  endtask

  task automatic cfg_read(input logic [1:0] idx, input logic [1:0] fld,
                          input logic [PL-1:0] exp_data, input logic exp_err, input string tag);
    cfg_req_i = 1'b1; cfg_we_i = 1'b0; cfg_idx_i = idx; cfg_field_i = fld; cfg_wdata_i = '0;
    tick;
    cfg_req_i = 1'b0;
    chk({tag, ".rvalid"}, cfg_rvalid_o, 1'b1);
    chk({tag, ".rdata"}, cfg_rdata_o, exp_data);
    chk({tag, ".err"}, cfg_err_o, exp_err);
  endtask

  task automatic lookup(input int port, input logic [PL-1:0] addr,
                        input logic exp_hit, input logic [2:0] exp_attr, input string tag);
    lk_valid_i = '0;
    lk_valid_i[port] = 1'b1;
    lk_addr_i[port*PL +: PL] = addr;
    tick;
    lk_valid_i = '0;
    chk({tag, ".valid"}, lk_valid_o[port], 1'b1);
    chk({tag, ".hit"}, lk_hit_o[port], exp_hit);
    chk({tag, ".attr"}, lk_attr_o[port*3 +: 3], exp_attr);
  endtask

  initial begin
    rst_ni = 1'b0; cfg_req_i = 1'b0; cfg_we_i = 1'b0; cfg_idx_i = '0;
    cfg_field_i = '0; cfg_wdata_i = '0; lk_valid_i = 2'b11; lk_addr_i = '0;
    lk_ready_i = 2'b11;

    // Reset state; requests offered during reset are not captured
    #1;
    chk("rst.ready_o", lk_ready_o, 2'b11);
    tick; tick;
    chk("rst.lk_valid", lk_valid_o, 2'b00);
    chk("rst.lk_hit", lk_hit_o, 2'b00);
    chk("rst.lk_attr", lk_attr_o, 6'b0);
    chk("rst.cfg_rvalid", cfg_rvalid_o, 1'b0);
    chk("rst.cfg_rdata", cfg_rdata_o, 34'h0);
    chk("rst.cfg_err", cfg_err_o, 1'b0);
    lk_valid_i = '0;
    rst_ni = 1'b1;
    tick;
    chk("idle.lk_valid", lk_valid_o, 2'b00);

    // Reset table contents
    cfg_read(2'd0, 2'd0, 34'h0_8000_0000, 1'b0, "rd.r0base");
    cfg_read(2'd0, 2'd1, 34'h0_4000_0000, 1'b0, "rd.r0len");
    cfg_read(2'd0, 2'd2, 34'h3, 1'b0, "rd.r0attr");
    cfg_read(2'd0, 2'd3, 34'h0, 1'b1, "rd.field3");
    lookup(0, 34'h0_8000_1000, 1'b1, 3'b011, "lk.rst_hit");
    lookup(1, 34'h0_0000_1000, 1'b0, 3'b100, "lk.rst_miss");

    // Boundaries and priority
    cfg_write(2'd0, 2'd0, 34'h1000, 1'b0, "wr.r0base");
    cfg_write(2'd0, 2'd1, 34'h1000, 1'b0, "wr.r0len");
    cfg_write(2'd0, 2'd2, 34'h1, 1'b0, "wr.r0attr");
    cfg_write(2'd1, 2'd0, 34'h0, 1'b0, "wr.r1base");
    cfg_write(2'd1, 2'd1, 34'h10000, 1'b0, "wr.r1len");
    cfg_write(2'd1, 2'd2, 34'h2, 1'b0, "wr.r1attr");
    lookup(0, 34'h1FFF, 1'b1, 3'b001, "lk.top_r0");
    lookup(1, 34'h2000, 1'b1, 3'b010, "lk.past_r0");
    lookup(0, 34'h1000, 1'b1, 3'b001, "lk.base_r0");
    lookup(1, 34'h0FFF, 1'b1, 3'b010, "lk.below_r0");
    cfg_write(2'd3, 2'd0, 34'h3_FFFF_F000, 1'b0, "wr.r3base");
    cfg_write(2'd3, 2'd1, 34'h1000, 1'b0, "wr.r3len");
    cfg_write(2'd3, 2'd2, 34'h7, 1'b0, "wr.r3attr");
    lookup(0, 34'h3_FFFF_FFFF, 1'b1, 3'b111, "lk.topaddr");
    cfg_write(2'd2, 2'd0, 34'h3_0000_0000, 1'b0, "wr.r2base");
    lookup(1, 34'h3_0000_0000, 1'b0, 3'b100, "lk.len0");

    // Lock
    cfg_write(2'd2, 2'd2, 34'hA, 1'b0, "wr.lock");
    cfg_read(2'd2, 2'd2, 34'hA, 1'b0, "rd.lock");
    cfg_write(2'd2, 2'd0, 34'h1234, 1'b1, "wr.locked_base");
    cfg_read(2'd2, 2'd0, 34'h3_0000_0000, 1'b0, "rd.locked_base");
    cfg_write(2'd2, 2'd2, 34'h0, 1'b1, "wr.locked_attr");
    cfg_write(2'd1, 2'd3, 34'h5, 1'b1, "wr.field3");

    // Backpressure on port0 with a rule rewrite; port1 keeps streaming
    lk_ready_i = 2'b10; lk_valid_i = 2'b11;
    lk_addr_i[0 +: PL] = 34'h1800; lk_addr_i[PL +: PL] = 34'h0100;
    tick;
    chk("bp.v0", lk_valid_o[0], 1'b1);
    chk("bp.a0", lk_attr_o[2:0], 3'b001);
    chk("bp.rdy0", lk_ready_o[0], 1'b0);
    chk("bp.a1_0", lk_attr_o[5:3], 3'b010);
    lk_addr_i[0 +: PL] = 34'h0010; lk_addr_i[PL +: PL] = 34'h5000;
    cfg_req_i = 1'b1; cfg_we_i = 1'b1; cfg_idx_i = 2'd0; cfg_field_i = 2'd2; cfg_wdata_i = 34'h4;
    tick;
    cfg_req_i = 1'b0;
    chk("bp.cfg_err", cfg_err_o, 1'b0);
    chk("bp.a0_s1", lk_attr_o[2:0], 3'b001);
    chk("bp.h0_s1", lk_hit_o[0], 1'b1);
    chk("bp.rdy0_s1", lk_ready_o[0], 1'b0);
    chk("bp.v1_s1", lk_valid_o[1], 1'b1);
    chk("bp.a1_s1", lk_attr_o[5:3], 3'b010);
    lk_addr_i[PL +: PL] = 34'h20000;
    tick;
    chk("bp.a0_s2", lk_attr_o[2:0], 3'b001);
    chk("bp.h1_s2", lk_hit_o[1], 1'b0);
    chk("bp.a1_s2", lk_attr_o[5:3], 3'b100);
    lk_addr_i[PL +: PL] = 34'h3_FFFF_FFFF;
    tick;
    chk("bp.a0_s3", lk_attr_o[2:0], 3'b001);
    chk("bp.v0_s3", lk_valid_o[0], 1'b1);
    chk("bp.a1_s3", lk_attr_o[5:3], 3'b111);
    lk_ready_i = 2'b11; lk_valid_i = 2'b01;
    #1;
    chk("bp.rdy0_rel", lk_ready_o[0], 1'b1);
    tick;
    lk_valid_i = '0;
    chk("bp.v0_next", lk_valid_o[0], 1'b1);
    chk("bp.a0_next", lk_attr_o[2:0], 3'b010);
    tick;
    chk("bp.drain", lk_valid_o, 2'b00);

    // Write and lookup in the same cycle
    cfg_write(2'd0, 2'd2, 34'h1, 1'b0, "wr.r0attr001");
    cfg_req_i = 1'b1; cfg_we_i = 1'b1; cfg_idx_i = 2'd0; cfg_field_i = 2'd2; cfg_wdata_i = 34'h6;
    lk_valid_i = 2'b01; lk_addr_i[0 +: PL] = 34'h1800;
    tick;
    cfg_req_i = 1'b0; lk_valid_i = '0;
    chk("same.attr", lk_attr_o[2:0], 3'b001);
    chk("same.err", cfg_err_o, 1'b0);
    lookup(0, 34'h1800, 1'b1, 3'b110, "lk.after_write");

    // Reset with a held result and a config request in flight
    lk_ready_i = 2'b00; lk_valid_i = 2'b01; lk_addr_i[0 +: PL] = 34'h1800;
    tick;
    chk("mid.held", lk_valid_o[0], 1'b1);
    rst_ni = 1'b0; cfg_req_i = 1'b1; cfg_we_i = 1'b0; cfg_idx_i = 2'd0; cfg_field_i = 2'd0;
    #1;
    chk("mid.rdy_in_rst", lk_ready_o, 2'b11);
    tick;
    chk("mid.lk_valid", lk_valid_o, 2'b00);
    chk("mid.cfg_rvalid", cfg_rvalid_o, 1'b0);
    rst_ni = 1'b1; cfg_req_i = 1'b0; lk_valid_i = '0; lk_ready_i = 2'b11;
    tick;
    chk("post.cfg_rvalid", cfg_rvalid_o, 1'b0);
    chk("post.lk_valid", lk_valid_o, 2'b00);
    cfg_write(2'd2, 2'd0, 34'h5000, 1'b0, "wr.unlocked");
    cfg_read(2'd2, 2'd2, 34'h0, 1'b0, "rd.r2attr_rst");
    cfg_read(2'd0, 2'd0, 34'h0_8000_0000, 1'b0, "rd.r0base_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
